// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_e;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  // Width needed to hold a fill level of 0..pat_w inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_window.sv
// PAT_W-bit compare window with a saturating fill level; clear wins over shift.
module seq_shift_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W  = 4,
  parameter int FILL_W = fill_width(PAT_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shift,
  input  logic              clear,
  input  logic              bit_in,
  output logic [PAT_W-1:0]  win,
  output logic [FILL_W-1:0] fill,
  output logic              full
);

  logic [PAT_W-1:0]  win_d,  win_q;
  logic [FILL_W-1:0] fill_d, fill_q;

  assign full = (fill_q == FILL_W'(PAT_W));
  assign win  = win_q;
  assign fill = fill_q;

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clear) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift) begin
      win_d  = {win_q[PAT_W-2:0], bit_in};
      fill_d = full ? fill_q : fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a runtime-loaded PAT_W-bit pattern with overlap mode
// and a saturating match counter; all outputs registered.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load,
  input  logic [PAT_W-1:0]              pattern,
  input  logic                          overlap,
  input  logic                          in_valid,
  input  logic                          in,
  output logic                          match,
  output logic [CNT_W-1:0]              match_count,
  output logic [fill_width(PAT_W)-1:0]  fill,
  output logic                          armed
);

  localparam int FILL_W = fill_width(PAT_W);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W out of range 2..16");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W out of range 1..32");
  end

  state_e           state_d, state_q;
  logic [PAT_W-1:0] pat_d, pat_q;
  logic             ovl_d, ovl_q;
  logic             match_d, match_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic [PAT_W-1:0]  win;
  logic [FILL_W-1:0] win_fill;
  logic              win_full;
  logic              accept, nxt_full, hit, shift, clear;
  logic [PAT_W-1:0]  nxt_win;

  seq_shift_window #(.PAT_W(PAT_W), .FILL_W(FILL_W)) u_win (
    .clock  (clock),
    .reset  (reset),
    .shift  (shift),
    .clear  (clear),
    .bit_in (in),
    .win    (win),
    .fill   (win_fill),
    .full   (win_full)
  );

  // A load owns the cycle: any bit offered alongside it is discarded.
  always_comb begin
    accept   = in_valid && (state_q != IDLE) && !load;
    nxt_win  = {win[PAT_W-2:0], in};
    nxt_full = win_full || (win_fill == FILL_W'(PAT_W - 1));
    hit      = accept && nxt_full && (nxt_win == pat_q);
    shift    = accept;
    clear    = load || (hit && !ovl_q);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    match_d = hit;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = FILL;
      pat_d   = pattern;
      ovl_d   = overlap;
      match_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FILL:    if (accept && nxt_full) state_d = HUNT;
        default: state_d = state_q;
      endcase
      // Non-overlapping mode restarts the fill after every match.
      if (hit && !ovl_q) state_d = FILL;
      if (hit && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign fill        = win_fill;
  assign armed       = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a PAT_W=4 instance for the main
// scenarios and a PAT_W=2/CNT_W=2 instance for counter saturation.
module tb_seq_detector_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       load_a = 1'b0, ovl_a = 1'b0, vld_a = 1'b0, in_a = 1'b0;
  logic [3:0] pat_a = '0;
  logic       match_a, armed_a;
  logic [7:0] cnt_a;
  logic [2:0] fill_a;

  logic       load_b = 1'b0, ovl_b = 1'b0, vld_b = 1'b0, in_b = 1'b0;
  logic [1:0] pat_b = '0;
  logic       match_b, armed_b;
  logic [1:0] cnt_b;
  logic [1:0] fill_b;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .load(load_a), .pattern(pat_a),
    .overlap(ovl_a), .in_valid(vld_a), .in(in_a), .match(match_a),
    .match_count(cnt_a), .fill(fill_a), .armed(armed_a)
  );

  seq_detector_param #(.PAT_W(2), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .load(load_b), .pattern(pat_b),
    .overlap(ovl_b), .in_valid(vld_b), .in(in_b), .match(match_b),
    .match_count(cnt_b), .fill(fill_b), .armed(armed_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_pat_a(input logic [3:0] p, input logic ov);
    load_a = 1'b1; pat_a = p; ovl_a = ov;
    tick();
    load_a = 1'b0;
  endtask

  // Offer one cycle on dut_a and check match/fill after the edge.
  task automatic step_a(input string tag, input logic v, input logic b,
                        input int exp_m, input int exp_f);
    vld_a = v; in_a = b;
    tick();
    vld_a = 1'b0;
    chk({tag, ".match"}, int'(match_a), exp_m);
    chk({tag, ".fill"},  int'(fill_a),  exp_f);
  endtask

  task automatic gap_a(input string tag, input int n, input int exp_f);
    for (int g = 0; g < n; g++) step_a(tag, 1'b0, 1'b1, 0, exp_f);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst.armed", int'(armed_a), 0);
    chk("rst.fill",  int'(fill_a),  0);
    chk("rst.count", int'(cnt_a),   0);
    chk("rst.match", int'(match_a), 0);
    step_a("idle_ignore", 1'b1, 1'b1, 0, 0);

    // Overlapping 1011 over 1,0,1,1,0,1,1
    load_pat_a(4'b1011, 1'b1);
    chk("ov.armed", int'(armed_a), 1);
    step_a("ov.b1", 1'b1, 1'b1, 0, 1);
    step_a("ov.b2", 1'b1, 1'b0, 0, 2);
    step_a("ov.b3", 1'b1, 1'b1, 0, 3);
    step_a("ov.b4", 1'b1, 1'b1, 1, 4);
    chk("ov.cnt4", int'(cnt_a), 1);
    step_a("ov.b5", 1'b1, 1'b0, 0, 4);
    step_a("ov.b6", 1'b1, 1'b1, 0, 4);
    step_a("ov.b7", 1'b1, 1'b1, 1, 4);
    chk("ov.count", int'(cnt_a), 2);

    // Non-overlapping: same stream, only one hit
    load_pat_a(4'b1011, 1'b0);
    chk("nov.cnt_clr", int'(cnt_a), 0);
    step_a("nov.b1", 1'b1, 1'b1, 0, 1);
    step_a("nov.b2", 1'b1, 1'b0, 0, 2);
    step_a("nov.b3", 1'b1, 1'b1, 0, 3);
    step_a("nov.b4", 1'b1, 1'b1, 1, 0);
    step_a("nov.b5", 1'b1, 1'b0, 0, 1);
    step_a("nov.b6", 1'b1, 1'b1, 0, 2);
    step_a("nov.b7", 1'b1, 1'b1, 0, 3);
    chk("nov.count", int'(cnt_a), 1);

    // in_valid gaps of 0..3 cycles between bits
    load_pat_a(4'b1011, 1'b1);
    step_a("gap.b1", 1'b1, 1'b1, 0, 1);
    gap_a("gap.g1", 2, 1);
    step_a("gap.b2", 1'b1, 1'b0, 0, 2);
    step_a("gap.b3", 1'b1, 1'b1, 0, 3);
    gap_a("gap.g3", 3, 3);
    step_a("gap.b4", 1'b1, 1'b1, 1, 4);
    gap_a("gap.g4", 1, 4);
    chk("gap.count", int'(cnt_a), 1);

    // Reset mid-stream, then reload
    load_pat_a(4'b1011, 1'b1);
    step_a("mr.b1", 1'b1, 1'b1, 0, 1);
    step_a("mr.b2", 1'b1, 1'b0, 0, 2);
    step_a("mr.b3", 1'b1, 1'b1, 0, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr.armed", int'(armed_a), 0);
    chk("mr.fill",  int'(fill_a),  0);
    step_a("mr.b4", 1'b1, 1'b1, 0, 0);
    chk("mr.armed2", int'(armed_a), 0);
    chk("mr.count",  int'(cnt_a),   0);
    load_pat_a(4'b1011, 1'b1);
    step_a("mr.r1", 1'b1, 1'b1, 0, 1);
    step_a("mr.r2", 1'b1, 1'b0, 0, 2);
    step_a("mr.r3", 1'b1, 1'b1, 0, 3);
    step_a("mr.r4", 1'b1, 1'b1, 1, 4);

    // Load 0110 mid-stream with a bit offered in the same cycle
    step_a("ml.b1", 1'b1, 1'b1, 0, 4);
    load_a = 1'b1; pat_a = 4'b0110; ovl_a = 1'b0; vld_a = 1'b1; in_a = 1'b1;
    tick();
    load_a = 1'b0; vld_a = 1'b0;
    chk("ml.fill",  int'(fill_a),  0);
    chk("ml.count", int'(cnt_a),   0);
    chk("ml.match", int'(match_a), 0);
    step_a("ml.b2", 1'b1, 1'b0, 0, 1);
    step_a("ml.b3", 1'b1, 1'b1, 0, 2);
    step_a("ml.b4", 1'b1, 1'b1, 0, 3);
    step_a("ml.b5", 1'b1, 1'b0, 1, 0);
    chk("ml.count2", int'(cnt_a), 1);

    // Saturating counter on the 2-bit instance: pattern 11, six 1s
    begin
      int exp_m [6] = '{0, 1, 1, 1, 1, 1};
      int exp_c [6] = '{0, 1, 2, 3, 3, 3};
      load_b = 1'b1; pat_b = 2'b11; ovl_b = 1'b1;
      tick();
      load_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
        vld_b = 1'b1; in_b = 1'b1;
        tick();
        chk($sformatf("sat.match%0d", i), int'(match_b), exp_m[i]);
        chk($sformatf("sat.cnt%0d", i),   int'(cnt_b),   exp_c[i]);
      end
      vld_b = 1'b0;
      tick();
      chk("sat.idle_match", int'(match_b), 0);
      chk("sat.hold_cnt",   int'(cnt_b),   3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
